// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered one-hot grant and an
// optional hold limit that preempts an owner while others are waiting.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst_n          - synchronous active-low reset
//   req            - per-requester request level, held while ownership is wanted
//   gnt            - registered one-hot-or-zero grant
//   gnt_valid      - registered, equals OR of gnt
//   gnt_id         - index of the granted requester, 0 when nothing is granted
//   preempt        - one-cycle pulse in the first cycle of a grant taken by the hold limit
//   dbg_state      - FSM state (0 = IDLE, 1 = BUSY)
//   dbg_ptr        - round-robin priority pointer
//   dbg_hold_cnt   - consecutive grant cycles of the current owner (saturating)
//
// Handshake: a requester raises req[i] and keeps it high; gnt[i] rises after
// an edge that sampled req[i] high. The owner keeps the grant while req[i]
// stays high, unless the hold limit is reached with another request pending.
// Dropping req[i] releases the grant at the next edge.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic               preempt,
  output logic               dbg_state,
  output logic [IDW-1:0]     dbg_ptr,
  output logic [7:0]         dbg_hold_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam bit         HOLD_EN    = (MAX_HOLD != 0);
  localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic                 preempt_q, preempt_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [7:0]           hold_q, hold_d;

  logic [NUM_REQ-1:0]   owner_mask;
  logic [NUM_REQ-1:0]   cand;
  logic                 owner_req;
  logic                 sel_found;
  logic [IDW-1:0]       sel_id;
  logic [IDW-1:0]       next_ptr;
  logic                 hi_found;
  logic [IDW-1:0]       hi_id;
  logic [IDW-1:0]       lo_id;

  // The current owner is never a candidate: whether it is leaving by release
  // or by preemption, the grant must move to somebody else.
  assign owner_mask = (state_q == BUSY) ? (NUM_REQ'(1) << gnt_id_q) : '0;
  assign cand       = req & ~owner_mask;
  assign owner_req  = |(req & owner_mask);
  assign sel_found  = |cand;

  // Round-robin pick: the lowest candidate at or above ptr wins; if there is
  // none, wrap around to the lowest candidate overall. The downward scan
  // leaves the lowest index in each result.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_id = IDW'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    sel_id = hi_found ? hi_id : lo_id;
  end

  assign next_ptr = (sel_id == IDW'(NUM_REQ - 1)) ? '0 : sel_id + IDW'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    preempt_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_d      = hold_q;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = BUSY;
          gnt_d       = NUM_REQ'(1) << sel_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = sel_id;
          ptr_d       = next_ptr;
          hold_d      = 8'd1;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          if (sel_found) begin
            // Direct hand-off, no idle cycle between owners.
            gnt_d       = NUM_REQ'(1) << sel_id;
            gnt_valid_d = 1'b1;
            gnt_id_d    = sel_id;
            ptr_d       = next_ptr;
            hold_d      = 8'd1;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
            hold_d      = 8'd0;
          end
        end else if (HOLD_EN && (hold_q >= MAX_HOLD_L) && sel_found) begin
          gnt_d       = NUM_REQ'(1) << sel_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = sel_id;
          ptr_d       = next_ptr;
          hold_d      = 8'd1;
          preempt_d   = 1'b1;
        end else begin
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_valid    = gnt_valid_q;
  assign gnt_id       = gnt_id_q;
  assign preempt      = preempt_q;
  assign dbg_state    = state_q;
  assign dbg_ptr      = ptr_q;
  assign dbg_hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed bench for rr_arbiter with NUM_REQ=4, MAX_HOLD=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;
  logic       dbg_state;
  logic [1:0] dbg_ptr;
  logic [7:0] dbg_hold_cnt;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(
    .NUM_REQ (4),
    .MAX_HOLD(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .preempt     (preempt),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr),
    .dbg_hold_cnt(dbg_hold_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b valid=%b id=%0d pre=%b, want 0000 0 0 0",
               gnt, gnt_valid, gnt_id, preempt);
    end
    checks++;
    if (dbg_state !== 1'b0 || dbg_ptr !== 2'd0 || dbg_hold_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: state=%b ptr=%0d hold=%0d, want 0 0 0",
               dbg_state, dbg_ptr, dbg_hold_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_valid !== 1'b1 || gnt_id !== 2'd2 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gnt=%b valid=%b id=%0d pre=%b, want 0100 1 2 0",
               gnt, gnt_valid, gnt_id, preempt);
    end
    checks++;
    if (dbg_ptr !== 2'd3 || dbg_hold_cnt !== 8'd1 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL single_grant_state: ptr=%0d hold=%0d state=%b, want 3 1 1",
               dbg_ptr, dbg_hold_cnt, dbg_state);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    int         exp_owner;
    logic       exp_pre;
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_owner = ((k - 1) / 3) % 4;
      exp_gnt   = 4'b0001 << exp_owner;
      exp_pre   = (k > 1) && (((k - 1) % 3) == 0);
      checks++;
      if (gnt !== exp_gnt || gnt_id !== 2'(exp_owner) || preempt !== exp_pre) begin
        errors++;
        $display("FAIL rotation cycle %0d: gnt=%b id=%0d pre=%b, want %b %0d %b",
                 k, gnt, gnt_id, preempt, exp_gnt, exp_owner, exp_pre);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_handoff();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL handoff_hold: gnt=%b, want 0010", gnt);
    end
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || preempt !== 1'b0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL handoff: gnt=%b id=%0d pre=%b valid=%b, want 1000 3 0 1",
               gnt, gnt_id, preempt, gnt_valid);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_single_long();
    int bad;
    do_reset();
    req = 4'b0100;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL single_long cycle %0d: gnt=%b pre=%b, want 0100 0", k, gnt, preempt);
      end
    end
    checks++;
    if (dbg_hold_cnt !== 8'd20) begin
      errors++;
      $display("FAIL single_long_hold: hold=%0d, want 20", dbg_hold_cnt);
    end
  endtask

  // Continues from test_single_long: requester 2 owns, ptr=3.
  task automatic test_release_idle();
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: gnt=%b valid=%b id=%0d state=%b, want 0000 0 0 0",
               gnt, gnt_valid, gnt_id, dbg_state);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL release_regrant: gnt=%b id=%0d valid=%b, want 0001 0 1",
               gnt, gnt_id, gnt_valid);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || dbg_ptr !== 2'd2) begin
      errors++;
      $display("FAIL mid_reset_setup: gnt=%b ptr=%0d, want 0010 2", gnt, dbg_ptr);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || preempt !== 1'b0 ||
        dbg_state !== 1'b0 || dbg_ptr !== 2'd0 || dbg_hold_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b valid=%b id=%0d pre=%b state=%b ptr=%0d hold=%0d, want all 0",
               gnt, gnt_valid, gnt_id, preempt, dbg_state, dbg_ptr, dbg_hold_cnt);
    end
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || dbg_ptr !== 2'd1) begin
      errors++;
      $display("FAIL mid_reset_regrant: gnt=%b id=%0d ptr=%0d, want 0001 0 1",
               gnt, gnt_id, dbg_ptr);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single_grant();
    test_rotation();
    test_handoff();
    test_single_long();
    test_release_idle();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter sharing a single resource among `NUM_REQ` requesters with a registered, one-hot grant. A requester keeps ownership while it holds its request. An optional hold limit preempts an owner that monopolises the resource while others wait. The block is the scheduler in front of the shared datapath, and its request/grant behaviour is written as implication properties for the formal flow.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before preemption when another request is pending. 0 disables preemption. Legal range 0..255.
- `clk`  in  1: sole clock; all state updates on posedge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req`  in  `NUM_REQ`: per-requester request level; held high for as long as ownership is wanted.
- `gnt`  out  `NUM_REQ`: one-hot-or-zero grant, registered.
- `gnt_valid`  out  1: equals OR of `gnt`, registered.
- `gnt_id`  out  `max(1,$clog2(NUM_REQ))`: index of the granted requester; 0 when `gnt_valid`=0.
- `preempt`  out  1: one-cycle pulse in the first cycle of a grant that was taken from an owner by the hold limit.

## Operation
- State: `IDLE` (no owner) or `BUSY` (owner `k`). Priority pointer `ptr` (requester index) and hold counter `hold_cnt` (8 bits, saturating).
- Selection: the first `i` with `req[i]`=1, scanning `ptr`, `ptr+1`, … modulo `NUM_REQ`, excluding the current owner when one is leaving. Whenever a grant is issued to `i`, `ptr` becomes `(i+1) mod NUM_REQ`.
- `IDLE`, any `req` high: grant the selected `i`, go to `BUSY`, set `hold_cnt`=1.
- `IDLE`, no `req` high: stay; outputs 0.
- `BUSY`, `req[k]`=0 (release):
  - If another request is pending, hand off directly to the next selected requester, with no idle gap. `hold_cnt`=1, `preempt`=0.
  - Otherwise clear `gnt` and go to `IDLE`.
- `BUSY`, `req[k]`=1:
  - If `MAX_HOLD`≠0, `hold_cnt`≥`MAX_HOLD` and another request is pending, preempt: grant the next selected requester (excluding `k`), `hold_cnt`=1, `preempt`=1 for that cycle.
  - Otherwise keep `k` and increment `hold_cnt`, saturating at 255.
- A preempted or released requester that still, or again, requests waits for its round-robin turn like any other.
- Single-requester case: the owner is never preempted, however long it holds.
- Invariants for verification:
  - `gnt` is one-hot-or-zero.
  - `gnt[i]` is set only if `req[i]` was high on the previous edge.
  - `gnt_id`/`gnt_valid` are consistent with `gnt`.
  - `preempt` implies `gnt_valid`.

## Timing
- Reset: on any edge with `rst_n`=0, all of the following take effect at that edge, including in mid-grant:
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `preempt`=0.
  - State `IDLE`, `ptr`=0, `hold_cnt`=0.
- Latency: `req` sampled high in `IDLE` at edge N gives `gnt` high after edge N. In SVA terms, `$rose(req[i]) && !gnt_valid && (only requester) |=> gnt[i]`.
- Release: `req[k]` sampled low at edge M gives `gnt[k]`=0 after edge M. The next owner's `gnt` rises at the same edge.
- Preemption: an owner receives exactly `MAX_HOLD` grant cycles before losing the grant, provided a competing request is pending at the decision edge.
- Fairness bound: with all requesters continuously requesting, each waits at most `(NUM_REQ-1)*MAX_HOLD` cycles for a grant when `MAX_HOLD`≠0.
- `preempt` is high for exactly one cycle per preemption. It never asserts on voluntary release.

## Test plan
- Reset, then `req`=0100 (`NUM_REQ`=4): `gnt`=0100 one cycle later, `gnt_id`=2, `ptr`=3.
- `req`=1111 held constant, `MAX_HOLD`=3: grants rotate 0→1→2→3→0. Each lasts 3 cycles, and `preempt` pulses at each change after the first.
- Owner 1 drops `req` while `req[3]`=1: `gnt` goes 0010→1000 on the next edge with no zero cycle; `preempt`=0.
- Only `req[2]` high for 20 cycles, `MAX_HOLD`=3: `gnt`=0100 stays throughout; `hold_cnt`=20; no `preempt`.
- Owner releases with no other request pending: `gnt`=0 next cycle; a new `req[0]` one cycle later is granted after one further edge.
- `rst_n`=0 for one cycle while `gnt`=0010: all outputs 0 after that edge. With `req`=0011 afterwards, requester 0 is granted first (`ptr` reset to 0).
